// File: rtl/vpp_gen_seq_pkg.sv
// Shared types and constants for the sequential partial-product generator.
package vmul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } vpp_state_t;

   // Order in which the four cross products are produced.
   localparam logic [1:0] STEP_TR = 2'd0;
   localparam logic [1:0] STEP_TL = 2'd1;
   localparam logic [1:0] STEP_BR = 2'd2;
   localparam logic [1:0] STEP_BL = 2'd3;

endpackage

// File: rtl/vpp_gen_seq_if.sv
// Operand/result handshake bundle between the producer, the generator and vadd4.
interface vpp_gen_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] tl;
   logic [WIDTH-1:0] tr;
   logic [WIDTH-1:0] bl;
   logic [WIDTH-1:0] br;
   logic             busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, tl, tr, bl, br, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, tl, tr, bl, br, busy
   );
endinterface

// File: rtl/vpp_gen_seq_hmul.sv
// Shared unsigned HALF x HALF -> WIDTH multiplier, full precision.
module vmul_hmul #(
   parameter int HALF  = 4,
   parameter int WIDTH = 8
) (
   input  logic [HALF-1:0]  x_i,
   input  logic [HALF-1:0]  y_i,
   output logic [WIDTH-1:0] p_o
);
   assign p_o = WIDTH'(x_i) * WIDTH'(y_i);
endmodule

// File: rtl/vpp_gen_seq.sv
// Four-cycle partial-product generator: one shared half-width multiplier, one product per step.
//  state | meaning
//  IDLE  | waiting for an operand pair, in_ready high
//  CALC  | step 0..3 writes tr, tl, br, bl in that order
//  DONE  | result set presented, waiting for out_ready
module vpp_gen_seq
   import vmul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   vpp_gen_seq_if.slave bus
);
   localparam int HALF = WIDTH / 2;

   vpp_state_t       state_q;
   logic [1:0]       step_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] tl_q, tr_q, bl_q, br_q;
   logic             out_valid_q;
   logic             busy_q;

   logic [HALF-1:0]  x_d, y_d;
   logic [WIDTH-1:0] prod_d;
   logic             in_ready;
   logic             wr_tr, wr_tl, wr_br, wr_bl;

   // tl/bl use a_hi, br/bl use b_hi
   assign x_d = (step_q == STEP_TL || step_q == STEP_BL) ? a_q[WIDTH-1:HALF] : a_q[HALF-1:0];
   assign y_d = (step_q == STEP_BR || step_q == STEP_BL) ? b_q[WIDTH-1:HALF] : b_q[HALF-1:0];

   vmul_hmul #(
      .HALF  (HALF),
      .WIDTH (WIDTH)
   ) u_hmul (
      .x_i (x_d),
      .y_i (y_d),
      .p_o (prod_d)
   );

   assign wr_tr = (state_q == CALC) && (step_q == STEP_TR);
   assign wr_tl = (state_q == CALC) && (step_q == STEP_TL);
   assign wr_br = (state_q == CALC) && (step_q == STEP_BR);
   assign wr_bl = (state_q == CALC) && (step_q == STEP_BL);

   assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         step_q      <= STEP_TR;
         a_q         <= '0;
         b_q         <= '0;
         tl_q        <= '0;
         tr_q        <= '0;
         bl_q        <= '0;
         br_q        <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         if (wr_tr) tr_q <= prod_d;
         if (wr_tl) tl_q <= prod_d;
         if (wr_br) br_q <= prod_d;
         if (wr_bl) bl_q <= prod_d;

         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  step_q  <= STEP_TR;
                  state_q <= CALC;
                  busy_q  <= 1'b1;
               end
            end
            CALC: begin
               if (step_q == STEP_BL) begin
                  step_q      <= STEP_TR;
                  state_q     <= DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  step_q <= step_q + 2'd1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  // back-to-back: the next pair is taken in the same edge the result leaves
                  if (bus.in_valid) begin
                     a_q     <= bus.a;
                     b_q     <= bus.b;
                     step_q  <= STEP_TR;
                     state_q <= CALC;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               step_q      <= STEP_TR;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.tl        = tl_q;
   assign bus.tr        = tr_q;
   assign bus.bl        = bl_q;
   assign bus.br        = br_q;
endmodule

// File: tb/tb_vpp_gen_seq.sv
// Scoreboard bench for vpp_gen_seq: handshake model pushes expected operands, monitor checks results.
module tb_vpp_gen_seq;
   localparam int WIDTH = 8;
   localparam int HALF  = WIDTH / 2;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } pair_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   cyc_cnt;
   bit   m_pending;
   int   m_acc;
   pair_t q[$];

   vpp_gen_seq_if #(.WIDTH(WIDTH)) bus ();

   vpp_gen_seq #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc_cnt);
      end
   endtask

   // Handshake model: a result appears 4 edges after acceptance and stays until consumed.
   always @(negedge clk) begin
      bit mv, mb, mir;
      if (!rst) begin
         mv  = m_pending && (cyc_cnt >= m_acc + 4);
         mb  = m_pending && (cyc_cnt <  m_acc + 4);
         mir = !m_pending || (mv && bus.out_ready);
         chk("out_valid", bus.out_valid, mv);
         chk("busy",      bus.busy,      mb);
         chk("in_ready",  bus.in_ready,  mir);
         if (mv && bus.out_ready) m_pending = 1'b0;
         if (bus.in_valid && mir) begin
            q.push_back('{a: bus.a, b: bus.b});
            m_pending = 1'b1;
            m_acc     = cyc_cnt + 1;
         end
      end
   end

   // Result monitor: checks every cycle the set is presented, pops on consumption.
   always @(negedge clk) begin
      pair_t e;
      int ah, al, bh, bw;
      if (!rst && bus.out_valid === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=out_valid expected=no_result cycle=%0d", cyc_cnt);
         end else begin
            e  = q[0];
            ah = int'(e.a) / (1 << HALF);
            al = int'(e.a) % (1 << HALF);
            bh = int'(e.b) / (1 << HALF);
            bw = int'(e.b) % (1 << HALF);
            chk("tr", bus.tr, al * bw);
            chk("tl", bus.tl, ah * bw);
            chk("br", bus.br, al * bh);
            chk("bl", bus.bl, ah * bh);
            chk("recombined",
                int'(bus.bl) * (1 << WIDTH) + (int'(bus.tl) + int'(bus.br)) * (1 << HALF) + int'(bus.tr),
                int'(e.a) * int'(e.b));
            if (bus.out_ready) void'(q.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int i;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      i = 0;
      while ((q.size() != 0 || m_pending) && i < 60) begin
         tick(1);
         i++;
      end
      tick(1);
      chk("drain_done", (q.size() == 0 && !m_pending), 1);
   endtask

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      tick(1);
      bus.in_valid = 1'b0;
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_tl"},        bus.tl,        0);
      chk({tag, "_tr"},        bus.tr,        0);
      chk({tag, "_bl"},        bus.bl,        0);
      chk({tag, "_br"},        bus.br,        0);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_busy"},      bus.busy,      0);
      chk({tag, "_in_ready"},  bus.in_ready,  1);
   endtask

   initial begin
      int i;
      checks        = 0;
      errors        = 0;
      cyc_cnt       = 0;
      m_pending     = 1'b0;
      m_acc         = -100;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a         = '0;
      bus.b         = '0;
      tick(3);
      rst = 1'b0;
      @(negedge clk);
      check_idle_zero("reset");
      tick(1);

      // operands change during CALC; result must follow the latched pair
      bus.out_ready = 1'b1;
      send(8'h12, 8'h34);
      bus.a = 8'hAB;
      bus.b = 8'h77;
      drain();

      send(8'hFF, 8'hFF);
      drain();
      send(8'h00, 8'hC7);
      drain();

      // backpressure with competing operands offered
      bus.out_ready = 1'b0;
      send(8'h5A, 8'hC3);
      i = 0;
      while (!(m_pending && cyc_cnt >= m_acc + 4) && i < 20) begin
         tick(1);
         i++;
      end
      chk("bp_reached_done", (m_pending && cyc_cnt >= m_acc + 4), 1);
      bus.in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         bus.a = 8'($urandom);
         bus.b = 8'($urandom);
         tick(1);
      end
      drain();

      // back-to-back: second pair taken in the same edge the first result leaves
      bus.out_ready = 1'b1;
      bus.a         = 8'h12;
      bus.b         = 8'h34;
      bus.in_valid  = 1'b1;
      tick(1);
      bus.a = 8'hFF;
      bus.b = 8'h01;
      tick(5);
      drain();

      // reset while in CALC step 2 aborts the pending result
      send(8'h9C, 8'h6B);
      tick(2);
      rst = 1'b1;
      q.delete();
      m_pending = 1'b0;
      @(negedge clk);
      check_idle_zero("abort");
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      check_idle_zero("after_abort");
      tick(1);
      send(8'hE4, 8'h3D);
      drain();

      for (int k = 0; k < 400; k++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.a         = 8'($urandom);
         bus.b         = 8'($urandom);
         tick(1);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
